// File: rtl/logits_streamer_pkg.sv
// logits_streamer_pkg: shared sizes, FSM state encoding and error bit positions
package logits_streamer_pkg;
   localparam int NUM_CLASSES    = 10;
   localparam int DATA_WIDTH     = 16;
   localparam int IDX_WIDTH      = 4;
   localparam int TIMEOUT_CYCLES = 64;
   localparam int ERR_WR   = 0;
   localparam int ERR_BUSY = 1;
   localparam int ERR_TMO  = 2;
   localparam int ERR_IDX  = 3;
   typedef enum logic [2:0] {
      S_IDLE, S_KICK, S_STREAM, S_WAIT_RES, S_LOOKUP, S_DONE
   } state_t;
endpackage

// File: rtl/logits_streamer_if.sv
// logits_streamer_if: argmax handshake (start, logit beats, finish, winning index)
// master = logits producer, slave = argmax consumer
interface logits_streamer_if;
   import logits_streamer_pkg::*;
   logic                         start_argmax;
   logic                         data_valid;
   logic signed [DATA_WIDTH-1:0] class_out;
   logic                         finish_argmax;
   logic [IDX_WIDTH-1:0]         index_in;
   modport master (output start_argmax, data_valid, class_out, input finish_argmax, index_in);
   modport slave  (input start_argmax, data_valid, class_out, output finish_argmax, index_in);
endinterface

// File: rtl/logits_streamer_score_buffer.sv
// logits_streamer_score_buffer: NUM_CLASSES x DATA_WIDTH logit register file
// ports: one sync-reset write port (we/wr_addr/wr_data), combinational reads a (stream) and b (lookup)
module logits_streamer_score_buffer
   import logits_streamer_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         we,
   input  logic [IDX_WIDTH-1:0]         wr_addr,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   input  logic [IDX_WIDTH-1:0]         rd_addr_a,
   input  logic [IDX_WIDTH-1:0]         rd_addr_b,
   output logic signed [DATA_WIDTH-1:0] rd_data_a,
   output logic signed [DATA_WIDTH-1:0] rd_data_b
);
   logic signed [DATA_WIDTH-1:0] mem [NUM_CLASSES];
   always_ff @(posedge clk) begin
      if (reset)
         for (int i = 0; i < NUM_CLASSES; i++) mem[i] <= '0;
      else if (we)
         mem[wr_addr] <= wr_data;
   end
   // out-of-range reads return 0, which is also the score reported for a bad index
   assign rd_data_a = int'(rd_addr_a) < NUM_CLASSES ? mem[rd_addr_a] : '0;
   assign rd_data_b = int'(rd_addr_b) < NUM_CLASSES ? mem[rd_addr_b] : '0;
endmodule

// File: rtl/logits_streamer.sv
// logits_streamer: buffers class logits, streams them to argmax, returns the winning class and score
// ports: clk/reset; wr_en/wr_addr/wr_data logit writes; start_stream request; err_clear;
//        am (argmax master handshake); busy, result_valid/result_index/result_score, err_status
module logits_streamer
   import logits_streamer_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [IDX_WIDTH-1:0]         wr_addr,
   input  logic signed [DATA_WIDTH-1:0] wr_data,
   input  logic                         start_stream,
   input  logic                         err_clear,
   output logic                         busy,
   logits_streamer_if.master            am,
   output logic                         result_valid,
   output logic [IDX_WIDTH-1:0]         result_index,
   output logic signed [DATA_WIDTH-1:0] result_score,
   output logic [3:0]                   err_status
);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   state_t                       state, state_n;
   logic [IDX_WIDTH-1:0]         beat_cnt, beat_cnt_n, index_n;
   logic [TW-1:0]                tmo, tmo_n;
   logic [3:0]                   err_n;
   logic                         wr_ok, idx_bad;
   logic signed [DATA_WIDTH-1:0] stream_rd, lookup_rd;
   assign wr_ok   = wr_en && (state == S_IDLE || state == S_DONE) && int'(wr_addr) < NUM_CLASSES;
   assign idx_bad = int'(result_index) >= NUM_CLASSES;
   logits_streamer_score_buffer u_buf (
      .clk(clk), .reset(reset), .we(wr_ok), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_addr_a(beat_cnt_n), .rd_addr_b(result_index),
      .rd_data_a(stream_rd), .rd_data_b(lookup_rd)
   );
   always_comb begin
      state_n    = state;
      beat_cnt_n = beat_cnt;
      tmo_n      = tmo;
      index_n    = result_index;
      err_n      = err_clear ? '0 : err_status;
      err_n[ERR_WR]   = err_n[ERR_WR] | (wr_en && !wr_ok);
      err_n[ERR_BUSY] = err_n[ERR_BUSY] | (start_stream && state != S_IDLE);
      case (state)
         S_IDLE:
            if (start_stream) begin
               state_n    = S_KICK;
               beat_cnt_n = '0;
            end
         S_KICK: state_n = S_STREAM;
         S_STREAM:
            if (beat_cnt == IDX_WIDTH'(NUM_CLASSES - 1)) begin
               state_n = S_WAIT_RES;
               tmo_n   = '0;
            end else
               beat_cnt_n = beat_cnt + IDX_WIDTH'(1);
         S_WAIT_RES:
            if (am.finish_argmax) begin
               state_n = S_LOOKUP;
               index_n = am.index_in;
            end else if (tmo == TW'(TIMEOUT_CYCLES - 1)) begin
               state_n        = S_IDLE;
               err_n[ERR_TMO] = 1'b1;
            end else
               tmo_n = tmo + TW'(1);
         S_LOOKUP: begin
            state_n        = S_DONE;
            err_n[ERR_IDX] = err_n[ERR_IDX] | idx_bad;
         end
         default: state_n = S_IDLE;
      endcase
   end
   // outputs are registered from the next state so they line up with the state they describe
   always_ff @(posedge clk) begin
      if (reset) begin
         state           <= S_IDLE;
         beat_cnt        <= '0;
         tmo             <= '0;
         busy            <= 1'b0;
         am.start_argmax <= 1'b0;
         am.data_valid   <= 1'b0;
         am.class_out    <= '0;
         result_valid    <= 1'b0;
         result_index    <= '0;
         result_score    <= '0;
         err_status      <= '0;
      end else begin
         state           <= state_n;
         beat_cnt        <= beat_cnt_n;
         tmo             <= tmo_n;
         busy            <= state_n != S_IDLE;
         am.start_argmax <= state_n == S_KICK;
         am.data_valid   <= state_n == S_STREAM;
         am.class_out    <= state_n == S_STREAM ? stream_rd : '0;
         result_valid    <= state_n == S_DONE;
         result_index    <= index_n;
         result_score    <= state == S_LOOKUP ? lookup_rd : result_score;
         err_status      <= err_n;
      end
   end
endmodule
